// File: rtl/arbiter_stream_mux_if.sv
// rtl/arbiter_stream_mux_if.sv - core FIFO read bus plus output word stream
interface arbiter_stream_mux_if #(
   parameter int NUM_CORES  = 8,
   parameter int DATA_WIDTH = 32
);
   logic [NUM_CORES*DATA_WIDTH-1:0] data_in;
   logic [NUM_CORES-1:0]            valid_in;
   logic [NUM_CORES-1:0]            empty_in;
   logic [NUM_CORES-1:0]            rd_en;
   logic [DATA_WIDTH-1:0]           out_data;
   logic                            out_valid;
   logic                            out_ready;

   modport master (
      input  data_in, valid_in, empty_in, out_ready,
      output rd_en, out_data, out_valid
   );

   modport slave (
      output data_in, valid_in, empty_in, out_ready,
      input  rd_en, out_data, out_valid
   );
endinterface

// File: rtl/arbiter_stream_mux.sv
// rtl/arbiter_stream_mux.sv - drains selected core FIFOs in index order into one stream
// Fixed-count or drain-until-empty bursts, optional trailer word per core.
module arbiter_stream_mux #(
   parameter int NUM_CORES  = 8,
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 8,
   parameter int IDX_WIDTH  = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [NUM_CORES-1:0] core_select,
   input  logic [CNT_WIDTH-1:0] num_words,
   input  logic                 mode,
   input  logic                 trailer_en,
   output logic                 idle,
   output logic                 done,
   arbiter_stream_mux_if.master bus
);
   typedef enum logic [2:0] {S_IDLE, S_SCAN, S_XFER, S_TAIL, S_FLUSH} state_t;

   state_t                r_state, w_next;
   logic [NUM_CORES-1:0]  r_sel;
   logic [CNT_WIDTH-1:0]  r_num, r_issued, r_recv;
   logic                  r_mode, r_trl, r_in_flight, r_done;
   logic [IDX_WIDTH-1:0]  r_idx;
   logic [DATA_WIDTH-1:0] r_buf [4];
   logic [1:0]            r_wp, r_rp;
   logic [2:0]            r_occ;

   logic                  w_last_core, w_issue, w_got, w_pop, w_xfer_end;
   logic                  w_push, w_adv_idx, w_clr_cnt;
   logic [2:0]            w_fill;
   logic [DATA_WIDTH-1:0] w_trailer, w_push_data;

   assign w_last_core = (r_idx == IDX_WIDTH'(NUM_CORES - 1));
   assign w_fill      = r_occ + {2'b00, r_in_flight};
   // Counting the outstanding read against occupancy keeps the 4-entry buffer from overflowing.
   assign w_issue     = (r_state == S_XFER) && (r_issued < r_num) &&
                        !bus.empty_in[r_idx] && (w_fill <= 3'd2);
   assign w_got       = (r_state == S_XFER) && bus.valid_in[r_idx];
   assign w_pop       = (r_occ != 3'd0) && bus.out_ready;
   assign w_xfer_end  = !r_in_flight &&
                        ((r_recv == r_num) || (r_mode && bus.empty_in[r_idx]));
   assign w_trailer   = {1'b1, {(DATA_WIDTH-1-CNT_WIDTH-IDX_WIDTH){1'b0}}, r_idx, r_recv};

   assign bus.rd_en     = w_issue ? ({{(NUM_CORES-1){1'b0}}, 1'b1} << r_idx) : '0;
   assign bus.out_valid = (r_occ != 3'd0);
   assign bus.out_data  = r_buf[r_rp];
   assign idle          = (r_state == S_IDLE);
   assign done          = r_done;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next      = r_state;
      w_push      = 1'b0;
      w_push_data = w_trailer;
      w_adv_idx   = 1'b0;
      w_clr_cnt   = 1'b0;
      case (r_state)
         S_IDLE: if (start) w_next = S_SCAN;
         S_SCAN: begin
            if (r_sel[r_idx]) begin
               w_clr_cnt = 1'b1;
               w_next    = S_XFER;
            end else if (w_last_core) begin
               w_next = S_FLUSH;
            end else begin
               w_adv_idx = 1'b1;
            end
         end
         S_XFER: begin
            w_push      = w_got;
            w_push_data = bus.data_in[r_idx*DATA_WIDTH +: DATA_WIDTH];
            if (w_xfer_end) begin
               if (r_trl) begin
                  w_next = S_TAIL;
               end else if (w_last_core) begin
                  w_next = S_FLUSH;
               end else begin
                  w_adv_idx = 1'b1;
                  w_next    = S_SCAN;
               end
            end
         end
         S_TAIL: begin
            if (r_occ <= 3'd3) begin
               w_push = 1'b1;
               if (w_last_core) begin
                  w_next = S_FLUSH;
               end else begin
                  w_adv_idx = 1'b1;
                  w_next    = S_SCAN;
               end
            end
         end
         S_FLUSH: if (r_occ == 3'd0) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sel       <= '0;
         r_num       <= '0;
         r_mode      <= 1'b0;
         r_trl       <= 1'b0;
         r_idx       <= '0;
         r_issued    <= '0;
         r_recv      <= '0;
         r_in_flight <= 1'b0;
         r_done      <= 1'b0;
         r_wp        <= '0;
         r_rp        <= '0;
         r_occ       <= '0;
      end else begin
         r_done <= (r_state == S_FLUSH) && (r_occ == 3'd0);
         if (r_state == S_IDLE && start) begin
            r_sel  <= core_select;
            r_num  <= num_words;
            r_mode <= mode;
            r_trl  <= trailer_en;
            r_idx  <= '0;
         end else if (w_adv_idx) begin
            r_idx <= r_idx + 1'b1;
         end
         if (w_clr_cnt) begin
            r_issued <= '0;
            r_recv   <= '0;
         end else begin
            if (w_issue) r_issued <= r_issued + 1'b1;
            if (w_got)   r_recv   <= r_recv + 1'b1;
         end
         // Read latency is one cycle, so a new issue always supersedes the returning one.
         if (w_issue)    r_in_flight <= 1'b1;
         else if (w_got) r_in_flight <= 1'b0;
         if (w_push) r_wp <= r_wp + 1'b1;
         if (w_pop)  r_rp <= r_rp + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_occ <= r_occ + 3'd1;
            2'b01:   r_occ <= r_occ - 3'd1;
            default: r_occ <= r_occ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_buf[r_wp] <= w_push_data;
   end
endmodule

// File: tb/tb_arbiter_stream_mux.sv
// tb/tb_arbiter_stream_mux.sv - directed self-checking bench for arbiter_stream_mux
module tb_arbiter_stream_mux;
   localparam int NC = 8;
   localparam int DW = 32;
   localparam int CW = 8;
   localparam int IW = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          mode = 1'b0;
   logic          trailer_en = 1'b0;
   logic [NC-1:0] core_select = '0;
   logic [CW-1:0] num_words = '0;
   logic          idle, done;

   int ntests = 0;
   int nfail  = 0;

   arbiter_stream_mux_if #(.NUM_CORES(NC), .DATA_WIDTH(DW)) bus ();

   arbiter_stream_mux #(.NUM_CORES(NC), .DATA_WIDTH(DW), .CNT_WIDTH(CW), .IDX_WIDTH(IW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .core_select(core_select),
      .num_words(num_words), .mode(mode), .trailer_en(trailer_en),
      .idle(idle), .done(done), .bus(bus)
   );

   always #5 clk = ~clk;

   // Source FIFO model: one-cycle read latency, registered empty flag.
   logic [DW-1:0] src_mem [NC][256];
   int            src_wr [NC];
   int            src_rd [NC];
   logic [NC-1:0] rd_seen;

   always @(negedge clk) rd_seen = bus.rd_en;

   always @(posedge clk) begin
      #1;
      for (int i = 0; i < NC; i++) begin
         bus.valid_in[i] = 1'b0;
         if (!rst_n) begin
            src_rd[i] = 0;
         end else if (rd_seen[i] && src_rd[i] < src_wr[i]) begin
            bus.data_in[i*DW +: DW] = src_mem[i][src_rd[i]];
            bus.valid_in[i] = 1'b1;
            src_rd[i] = src_rd[i] + 1;
         end
         bus.empty_in[i] = (src_rd[i] >= src_wr[i]);
      end
   end

   // Output and activity monitor, cleared while in reset.
   logic [DW-1:0] got [$];
   int rd_cnt [NC];
   int pushes, pops, max_occ, max_occ_low, done_cnt, occ_now;

   always @(negedge clk) begin
      if (!rst_n) begin
         got.delete();
         for (int i = 0; i < NC; i++) rd_cnt[i] = 0;
         pushes = 0; pops = 0; max_occ = 0; max_occ_low = 0; done_cnt = 0;
      end else begin
         occ_now = pushes - pops;
         if (occ_now > max_occ) max_occ = occ_now;
         if (!bus.out_ready && occ_now > max_occ_low) max_occ_low = occ_now;
         if (bus.out_valid && bus.out_ready) begin
            got.push_back(bus.out_data);
            pops++;
         end
         pushes += $countones(bus.valid_in);
         for (int i = 0; i < NC; i++) if (bus.rd_en[i]) rd_cnt[i]++;
         if (done) done_cnt++;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      start = 1'b0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < NC; i++) src_wr[i] = 0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic load(input int core, input logic [DW-1:0] base, input int n, input int avail);
      for (int k = 0; k < n; k++) src_mem[core][k] = base + DW'(k);
      src_wr[core] = avail;
   endtask

   task automatic kick(input logic [NC-1:0] sel, input int n, input logic m, input logic t);
      @(posedge clk);
      #1;
      core_select = sel;
      num_words   = CW'(n);
      mode        = m;
      trailer_en  = t;
      start       = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Leaves off in cycle 1 after start; returns the cycle in which done was seen.
   task automatic run(input int budget, input int rmode, input int feed_core,
                      output int cycles, output bit ok);
      ok = 1'b0;
      cycles = 0;
      for (int c = 1; c <= budget; c++) begin
         @(negedge clk);
         if (done) begin
            ok = 1'b1;
            cycles = c;
            break;
         end
         @(posedge clk);
         #1;
         if (rmode == 1) begin
            if (c < 20)      bus.out_ready = 1'b1;
            else if (c < 40) bus.out_ready = 1'b0;
            else             bus.out_ready = 1'($urandom_range(0, 1));
         end else begin
            bus.out_ready = 1'b1;
         end
         if (feed_core >= 0 && (c % 10) == 0 && src_wr[feed_core] < 4)
            src_wr[feed_core] = src_wr[feed_core] + 1;
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      ntests++;
      if (idle !== 1'b1 || done !== 1'b0) begin
         nfail++; $display("FAIL reset_idle_done got idle=%b done=%b want idle=1 done=0", idle, done);
      end
      ntests++;
      if (bus.out_valid !== 1'b0 || bus.rd_en !== '0) begin
         nfail++; $display("FAIL reset_outputs got out_valid=%b rd_en=%h want 0 0", bus.out_valid, bus.rd_en);
      end
      do_reset();
      @(negedge clk);
      ntests++;
      if (idle !== 1'b1 || bus.out_valid !== 1'b0) begin
         nfail++; $display("FAIL reset_release got idle=%b out_valid=%b want 1 0", idle, bus.out_valid);
      end
   endtask

   task automatic test_fixed(input logic trl);
      logic [DW-1:0] exp [$];
      int cyc;
      bit ok;
      do_reset();
      load(0, 32'h0000_0A00, 4, 4);
      load(2, 32'h0000_0C00, 4, 4);
      kick(8'h05, 3, 1'b0, trl);
      run(300, 0, -1, cyc, ok);
      if (trl) exp = '{32'hA00, 32'hA01, 32'hA02, 32'h8000_0003, 32'hC00, 32'hC01, 32'hC02, 32'h8000_0203};
      else     exp = '{32'hA00, 32'hA01, 32'hA02, 32'hC00, 32'hC01, 32'hC02};
      ntests++;
      if (!ok) begin nfail++; $display("FAIL fixed_done_seen trl=%b got timeout want done", trl); end
      ntests++;
      if (got.size() != exp.size()) begin
         nfail++; $display("FAIL fixed_len trl=%b got %0d want %0d", trl, got.size(), exp.size());
      end
      for (int k = 0; k < exp.size(); k++) begin
         ntests++;
         if (k >= got.size()) begin
            nfail++; $display("FAIL fixed_word%0d trl=%b got none want %h", k, trl, exp[k]);
         end else if (got[k] !== exp[k]) begin
            nfail++; $display("FAIL fixed_word%0d trl=%b got %h want %h", k, trl, got[k], exp[k]);
         end
      end
      ntests++;
      if (rd_cnt[0] != 3 || rd_cnt[2] != 3) begin
         nfail++; $display("FAIL fixed_rd_pulses got c0=%0d c2=%0d want 3 3", rd_cnt[0], rd_cnt[2]);
      end
      ntests++;
      if (rd_cnt[1] + rd_cnt[3] + rd_cnt[4] + rd_cnt[5] + rd_cnt[6] + rd_cnt[7] != 0) begin
         nfail++; $display("FAIL fixed_rd_other got nonzero reads on unselected cores want 0");
      end
      ntests++;
      if (done_cnt != 1 || idle !== 1'b1) begin
         nfail++; $display("FAIL fixed_done_pulse got count=%0d idle=%b want 1 1", done_cnt, idle);
      end
      ntests++;
      if (src_wr[0] - src_rd[0] != 1 || src_wr[2] - src_rd[2] != 1) begin
         nfail++; $display("FAIL fixed_leftover got c0=%0d c2=%0d want 1 1",
                           src_wr[0] - src_rd[0], src_wr[2] - src_rd[2]);
      end
   endtask

   task automatic test_drain();
      logic [DW-1:0] exp [$];
      int cyc;
      bit ok;
      do_reset();
      load(1, 32'h0000_0B00, 2, 2);
      kick(8'h02, 5, 1'b1, 1'b1);
      run(300, 0, -1, cyc, ok);
      exp = '{32'hB00, 32'hB01, 32'h8000_0102};
      ntests++;
      if (!ok) begin nfail++; $display("FAIL drain_done got timeout want done"); end
      ntests++;
      if (got.size() != exp.size()) begin
         nfail++; $display("FAIL drain_len got %0d want %0d", got.size(), exp.size());
      end
      for (int k = 0; k < exp.size(); k++) begin
         ntests++;
         if (k >= got.size()) begin
            nfail++; $display("FAIL drain_word%0d got none want %h", k, exp[k]);
         end else if (got[k] !== exp[k]) begin
            nfail++; $display("FAIL drain_word%0d got %h want %h", k, got[k], exp[k]);
         end
      end
      ntests++;
      if (rd_cnt[1] != 2) begin nfail++; $display("FAIL drain_rd_pulses got %0d want 2", rd_cnt[1]); end
   endtask

   task automatic test_backpressure();
      int cyc;
      int bad;
      bit ok;
      do_reset();
      load(3, 32'h0000_3000, 200, 200);
      kick(8'h08, 200, 1'b0, 1'b0);
      run(5000, 1, -1, cyc, ok);
      ntests++;
      if (!ok) begin nfail++; $display("FAIL bp_done got timeout want done"); end
      ntests++;
      if (got.size() != 200) begin nfail++; $display("FAIL bp_len got %0d want 200", got.size()); end
      bad = 0;
      for (int k = 0; k < 200 && k < got.size(); k++)
         if (got[k] !== 32'h3000 + 32'(k)) bad++;
      ntests++;
      if (bad != 0) begin nfail++; $display("FAIL bp_order got %0d wrong words want 0", bad); end
      ntests++;
      if (max_occ > 4) begin nfail++; $display("FAIL bp_occ_max got %0d want <=4", max_occ); end
      ntests++;
      if (max_occ_low > 3) begin nfail++; $display("FAIL bp_occ_stalled got %0d want <=3", max_occ_low); end
      ntests++;
      if (rd_cnt[3] != 200) begin nfail++; $display("FAIL bp_rd_pulses got %0d want 200", rd_cnt[3]); end
   endtask

   task automatic test_slow_source();
      int cyc;
      bit ok;
      do_reset();
      load(5, 32'h0000_5000, 4, 0);
      kick(8'h20, 4, 1'b0, 1'b0);
      run(400, 0, 5, cyc, ok);
      ntests++;
      if (!ok) begin nfail++; $display("FAIL slow_done got timeout want done"); end
      ntests++;
      if (got.size() != 4) begin nfail++; $display("FAIL slow_len got %0d want 4", got.size()); end
      for (int k = 0; k < 4; k++) begin
         ntests++;
         if (k >= got.size() || got[k] !== 32'h5000 + 32'(k)) begin
            nfail++; $display("FAIL slow_word%0d got %h want %h", k,
                              (k < got.size()) ? got[k] : 32'hx, 32'h5000 + 32'(k));
         end
      end
   endtask

   task automatic test_empty_select();
      int cyc;
      bit ok;
      do_reset();
      kick(8'h00, 3, 1'b0, 1'b1);
      run(60, 0, -1, cyc, ok);
      ntests++;
      if (!ok || cyc != 10) begin
         nfail++; $display("FAIL empty_sel_latency got ok=%0d cycle=%0d want cycle 10", ok, cyc);
      end
      ntests++;
      if (got.size() != 0) begin nfail++; $display("FAIL empty_sel_output got %0d words want 0", got.size()); end
   endtask

   task automatic test_async_reset();
      bit seen;
      do_reset();
      load(0, 32'h0000_0A00, 12, 12);
      bus.out_ready = 1'b0;
      kick(8'h01, 10, 1'b0, 1'b0);
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge clk);
         if (bus.out_valid) seen = 1'b1;
      end
      @(negedge clk);
      ntests++;
      if (bus.out_valid !== 1'b1 || idle !== 1'b0) begin
         nfail++; $display("FAIL arst_pre got out_valid=%b idle=%b want 1 0", bus.out_valid, idle);
      end
      #2 rst_n = 1'b0;
      #1;
      ntests++;
      if (bus.out_valid !== 1'b0 || bus.rd_en !== '0 || done !== 1'b0) begin
         nfail++; $display("FAIL arst_outputs got out_valid=%b rd_en=%h done=%b want 0 0 0",
                           bus.out_valid, bus.rd_en, done);
      end
      ntests++;
      if (idle !== 1'b1) begin nfail++; $display("FAIL arst_idle got %b want 1", idle); end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      test_fixed(1'b0);
   endtask

   initial begin
      bus.out_ready = 1'b1;
      test_reset();
      test_fixed(1'b0);
      test_fixed(1'b1);
      test_drain();
      test_backpressure();
      test_slow_source();
      test_empty_select();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end
endmodule

// File: doc/arbiter_stream_mux.md
# arbiter_stream_mux

Parametrised successor to the eight-core pipe-out arbiter. It drains a configurable set of per-core NeuRRAM I/O FIFOs into one valid/ready output word stream, core by core in ascending index order. Each burst has a per-core word budget and one of two modes: fixed count, or drain-until-empty. An optional trailer word tags each core's burst with the core index and the number of words actually sent. The block runs in the single system clock domain, ahead of the host-side clock-crossing pipe FIFO.

## Interface
- NUM_CORES, 8, number of source FIFOs.
- DATA_WIDTH, 32, word width.
- CNT_WIDTH, 8, width of word budget and counters.
- IDX_WIDTH, 3, core index width; must be ≥ clog2(NUM_CORES) and satisfy CNT_WIDTH+IDX_WIDTH < DATA_WIDTH.

- clk  in  1  system clock; one clock; all logic on posedge clk.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle start pulse; ignored unless idle=1.
- core_select  in  NUM_CORES  cores to drain; latched on start.
- num_words  in  CNT_WIDTH  per-core word budget; latched on start.
- mode  in  1  0=fixed count, 1=drain; latched on start.
- trailer_en  in  1  append trailer per core; latched on start.
- idle  out  1  high in IDLE.
- done  out  1  one-cycle pulse on return to IDLE.
- data_in  in  NUM_CORES*DATA_WIDTH  source data; core i occupies [i*DATA_WIDTH +: DATA_WIDTH].
- valid_in  in  NUM_CORES  source read-data valid, one cycle after rd_en.
- empty_in  in  NUM_CORES  source empty flags.
- rd_en  out  NUM_CORES  source read enables; at most one bit high.
- out_data  out  DATA_WIDTH  stream data.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready; a word transfers when out_valid & out_ready.

## Operation
- Internal 4-entry output FIFO buffer; out_data/out_valid come from its head. occ is its occupancy (0..4).
- in_flight flag: set on a cycle with a rd_en bit high, cleared on the cycle valid_in[idx] is high.
- States: IDLE, SCAN, XFER, TAIL, FLUSH.
- IDLE: on start, latch configuration, set idx=0, go to SCAN.
- SCAN: one core per cycle.
  - core_select[idx]=1: clear issued/recv counters, go to XFER.
  - Otherwise, if idx==NUM_CORES-1, go to FLUSH; else idx+1.
- XFER, issue rule: rd_en[idx] = (issued<num_words) & ~empty_in[idx] & (occ+in_flight ≤ 2).
  - Each issue increments issued.
  - Each valid_in[idx] pushes data_in slice into the buffer and increments recv.
  - valid_in on other indices is ignored.
- XFER exit when in_flight=0 and either:
  - recv==num_words (both modes), or
  - mode=1 and empty_in[idx]=1.
- XFER exit target: TAIL if trailer_en, otherwise next-core (below).
- TAIL: wait until occ≤3, then push trailer and go to next-core.
  - Trailer: bit DATA_WIDTH-1 = 1; bits [CNT_WIDTH+IDX_WIDTH-1:CNT_WIDTH] = idx; bits [CNT_WIDTH-1:0] = recv; all other bits 0.
- next-core: if idx==NUM_CORES-1 go to FLUSH, else idx+1 and go to SCAN.
- FLUSH: wait for occ==0, then go to IDLE and pulse done.
- Boundaries:
  - num_words=0: XFER exits immediately with no reads; trailer (if enabled) carries count 0.
  - core_select=0: SCAN walks all cores, then FLUSH, then done, with no output.
  - Fixed mode waits indefinitely on an empty source.
  - Buffer push and pop in the same cycle leave occ unchanged; the buffer never overflows (guaranteed by the issue rule).
- Reset (asynchronous, any state): state=IDLE, idle=1, done=0, out_valid=0, rd_en=0, occ=0, in_flight=0, counters=0, idx=0. Buffered data is discarded.

## Timing
- start at cycle 0: SCAN at cycle 1; first rd_en no earlier than cycle 2 (SCAN→XFER).
- rd_en (cycle n) → valid_in (n+1) → out_valid (n+2).
- Sustained rate is 1 word/cycle with out_ready=1 and a non-empty source.
- Each unselected core costs one SCAN cycle; each selected core costs one SCAN cycle plus its XFER cycles.
- rd_en is combinational from registered state and empty_in only; there is no path from out_ready.
- done asserts the cycle after the last word leaves the buffer.

## Test plan
1. Fixed mode with trailer_en=0, core_select=8'h05, num_words=3. Core0 preloaded with 0xA00..0xA03, core2 with 0xC00..0xC03, out_ready=1. Required: stream A00,A01,A02,C00,C01,C02; exactly 3 rd_en pulses per core; one done pulse; 0xA03 and 0xC03 left in their sources.
2. Same as test 1 with trailer_en=1. Required: 0x80000003 after A02 and 0x80000203 after C02.
3. Drain mode, core_select=8'h02, num_words=5, trailer_en=1, core1 holding 2 words. Required: 2 data words, then 0x80000102, then done; no hang.
4. Fixed mode, num_words=200, out_ready held low for 20 cycles mid-burst, then randomly toggled. Required: all 200 words in order with no loss or duplication; occ never exceeds 4; at most 3 words outstanding while out_ready is low.
5. Fixed mode, num_words=4, source initially empty, one word written every 10 cycles. Required: 4 words out, then done. Separately, core_select=0. Required: done pulse 10 cycles after start (SCAN through 8 cores, then FLUSH) and no output.
6. Assert rst_n=0 in XFER with occ=2. Required: out_valid, rd_en and done go to 0 and idle to 1 immediately. After release, a new start completes test 1 correctly.
